// File: rtl/serial_add_ctrl_pkg.sv
// Shared constants for the bit-serial adder controller: state encodings and index sizing.
package serial_add_ctrl_pkg;

  // Controller state encodings (binary, 2 bits)
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ADD_AB = 2'd1;
  localparam logic [1:0] ADD_C  = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  localparam int unsigned STATE_W = 2;

  // Bit-index register width: clog2(width), never narrower than one bit
  function automatic int unsigned idx_width(input int unsigned width);
    int unsigned w;
    w = 1;
    if (width > 1) begin
      w = $clog2(width);
    end
    return w;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_half_adder.sv
// Single-bit half adder cell; purely combinational.
module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic sum_c,
  output logic carry_c
);

  // Sum and carry of two bits
  always_comb begin
    sum_c   = a_i ^ b_i;
    carry_c = a_i & b_i;
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: reuses one half_adder twice per bit (a+b, then partial+carry)
// to form {cout,sum} = a + b + cin over 2*WIDTH busy cycles.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned     IDXW     = idx_width(WIDTH);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [IDXW-1:0]    idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               p_q, p_d;
  logic               c1_q, c1_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               ha_a_c;
  logic               ha_b_c;
  logic               ha_sum_c;
  logic               ha_carry_c;

  // Shared half-adder cell
  half_adder u_half_adder (
    .a_i     (ha_a_c),
    .b_i     (ha_b_c),
    .sum_c   (ha_sum_c),
    .carry_c (ha_carry_c)
  );

  // Operand mux: current operand bits in ADD_AB, partial sum + running carry in ADD_C
  always_comb begin
    ha_a_c = 1'b0;
    ha_b_c = 1'b0;
    case (state_q)
      ADD_AB: begin
        ha_a_c = a_q[0];
        ha_b_c = b_q[0];
      end
      ADD_C: begin
        ha_a_c = p_q;
        ha_b_c = carry_q;
      end
      default: begin
        ha_a_c = 1'b0;
        ha_b_c = 1'b0;
      end
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    p_d      = p_q;
    c1_d     = c1_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    sum_d    = sum_q;
    cout_d   = cout_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = ADD_AB;
        end
      end

      ADD_AB: begin
        p_d     = ha_sum_c;
        c1_d    = ha_carry_c;
        state_d = ADD_C;
      end

      ADD_C: begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
          if (idx_q == IDXW'(i)) begin
            result_d[i] = ha_sum_c;
          end
        end
        carry_d = c1_q | ha_carry_c;
        // Operands shift right so bit 0 always holds the bit being added
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        if (idx_q == LAST_IDX) begin
          // Publish on the FINISH entry edge so sum/cout are valid alongside done
          sum_d   = result_d;
          cout_d  = carry_d;
          state_d = FINISH;
        end else begin
          idx_d   = idx_q + IDXW'(1);
          state_d = ADD_AB;
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == ADD_AB) || (state_d == ADD_C);
    done_d = (state_d == FINISH);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      p_q      <= 1'b0;
      c1_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      p_q      <= p_d;
      c1_q     <= c1_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl at WIDTH=1, 4 and 8 with a per-instance expected-result queue.
module tb_serial_add_ctrl;

  logic clk;
  logic rst;

  logic       s1_start, s1_a, s1_b, s1_cin, s1_busy, s1_done, s1_sum, s1_cout;
  logic       s4_start, s4_cin, s4_busy, s4_done, s4_cout;
  logic [3:0] s4_a, s4_b, s4_sum;
  logic       s8_start, s8_cin, s8_busy, s8_done, s8_cout;
  logic [7:0] s8_a, s8_b, s8_sum;

  logic [32:0] sb1[$];
  logic [32:0] sb4[$];
  logic [32:0] sb8[$];

  int checks;
  int failures;

  serial_add_ctrl #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .start(s1_start), .a(s1_a), .b(s1_b), .cin(s1_cin),
    .busy(s1_busy), .done(s1_done), .sum(s1_sum), .cout(s1_cout)
  );

  serial_add_ctrl #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .start(s4_start), .a(s4_a), .b(s4_b), .cin(s4_cin),
    .busy(s4_busy), .done(s4_done), .sum(s4_sum), .cout(s4_cout)
  );

  serial_add_ctrl #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .start(s8_start), .a(s8_a), .b(s8_b), .cin(s8_cin),
    .busy(s8_busy), .done(s8_done), .sum(s8_sum), .cout(s8_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic cur_busy(input int w);
    case (w)
      1:       return s1_busy;
      4:       return s4_busy;
      default: return s8_busy;
    endcase
  endfunction

  function automatic logic cur_done(input int w);
    case (w)
      1:       return s1_done;
      4:       return s4_done;
      default: return s8_done;
    endcase
  endfunction

  function automatic logic [32:0] cur_res(input int w);
    case (w)
      1:       return 33'({s1_cout, s1_sum});
      4:       return 33'({s4_cout, s4_sum});
      default: return 33'({s8_cout, s8_sum});
    endcase
  endfunction

  // Drive a one-cycle start and queue the arithmetic result; returns in busy cycle 1
  task automatic start_op(input int w, input logic [31:0] av, input logic [31:0] bv,
                          input logic cv);
    logic [32:0] e;
    e = 33'(av) + 33'(bv) + 33'(cv);
    case (w)
      1: begin
        s1_a = av[0]; s1_b = bv[0]; s1_cin = cv; s1_start = 1'b1; sb1.push_back(e);
      end
      4: begin
        s4_a = av[3:0]; s4_b = bv[3:0]; s4_cin = cv; s4_start = 1'b1; sb4.push_back(e);
      end
      default: begin
        s8_a = av[7:0]; s8_b = bv[7:0]; s8_cin = cv; s8_start = 1'b1; sb8.push_back(e);
      end
    endcase
    tick();
    s1_start = 1'b0;
    s4_start = 1'b0;
    s8_start = 1'b0;
  endtask

  function automatic logic [32:0] pop_exp(input int w);
    logic [32:0] e;
    e = '1;
    case (w)
      1:       if (sb1.size() > 0) e = sb1.pop_front();
      4:       if (sb4.size() > 0) e = sb4.pop_front();
      default: if (sb8.size() > 0) e = sb8.pop_front();
    endcase
    return e;
  endfunction

  // Wait (bounded) for done starting at busy cycle n0, then check latency, result and pulse width
  task automatic wait_done(input int w, input int n0, input string nm);
    int          n;
    int          lat;
    bit          seen;
    logic [32:0] e;
    logic [32:0] got;
    n    = n0;
    lat  = 2 * w + 1;
    seen = 1'b0;
    while (!seen && n <= lat + 8) begin
      if (cur_done(w) === 1'b1) seen = 1'b1;
      else begin
        tick();
        n++;
      end
    end
    e = pop_exp(w);
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_timeout: no done within %0d cycles", nm, lat + 8);
    end else begin
      checks++;
      if (n !== lat) begin
        failures++;
        $display("FAIL %s_latency: done in cycle %0d, required cycle %0d", nm, n, lat);
      end
      got = cur_res(w);
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL %s_result: got {cout,sum}=%0h, required %0h", nm, got, e);
      end
      checks++;
      if (cur_busy(w) !== 1'b0) begin
        failures++;
        $display("FAIL %s_busy_at_done: got %b, required 0", nm, cur_busy(w));
      end
      tick();
      checks++;
      if (cur_done(w) !== 1'b0) begin
        failures++;
        $display("FAIL %s_done_pulse: done after pulse %b, required 0", nm, cur_done(w));
      end
    end
  endtask

  task automatic test_reset();
    int ws[3] = '{1, 4, 8};
    rst = 1'b1;
    tick();
    tick();
    foreach (ws[i]) begin
      checks++;
      if ({cur_busy(ws[i]), cur_done(ws[i]), cur_res(ws[i])} !== 35'd0) begin
        failures++;
        $display("FAIL reset_w%0d: busy=%b done=%b res=%0h, required all 0", ws[i],
                 cur_busy(ws[i]), cur_done(ws[i]), cur_res(ws[i]));
      end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_latency();
    int bad;
    bad = 0;
    start_op(4, 0, 0, 1'b0);
    for (int n = 1; n <= 8; n++) begin
      if (s4_busy !== 1'b1 || s4_done !== 1'b0) bad++;
      if (n < 8) tick();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL busy_window: %0d of 8 busy cycles wrong, required 0", bad);
    end
    tick();
    wait_done(4, 9, "zero_op");
  endtask

  task automatic test_basic();
    start_op(4, 15, 1, 1'b0);
    wait_done(4, 1, "add_15_1");
    start_op(4, 7, 8, 1'b1);
    wait_done(4, 1, "add_7_8_c");
  endtask

  task automatic test_ignored_start();
    int extra;
    start_op(4, 5, 9, 1'b0);
    tick();
    tick();
    checks++;
    if ({s4_cout, s4_sum} !== 5'h10) begin
      failures++;
      $display("FAIL hold_prev: got {cout,sum}=%0h during op, required 10", {s4_cout, s4_sum});
    end
    s4_a = 4'd3; s4_b = 4'd3; s4_start = 1'b1;
    tick();
    s4_start = 1'b0;
    wait_done(4, 4, "ignored_start");
    extra = 0;
    for (int k = 0; k < 12; k++) begin
      if (s4_busy !== 1'b0 || s4_done !== 1'b0) extra++;
      tick();
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL no_queued_op: %0d active cycles after ignored start, required 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    s4_a = 4'd2; s4_b = 4'd3; s4_cin = 1'b0; s4_start = 1'b1;
    sb4.push_back(33'd5);
    tick();
    s4_a = 4'd6; s4_b = 4'd7;
    sb4.push_back(33'd13);
    wait_done(4, 1, "b2b_first");
    checks++;
    if (s4_busy !== 1'b0 || s4_done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: busy=%b done=%b, required 0 0", s4_busy, s4_done);
    end
    tick();
    checks++;
    if (s4_busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_restart: busy=%b, required 1", s4_busy);
    end
    s4_start = 1'b0;
    wait_done(4, 1, "b2b_second");
  endtask

  task automatic test_reset_mid();
    start_op(4, 14, 3, 1'b0);
    void'(sb4.pop_back());
    for (int n = 1; n < 6; n++) tick();
    checks++;
    if ({s4_cout, s4_sum} !== 5'd14) begin
      failures++;
      $display("FAIL pre_reset_hold: got {cout,sum}=%0d, required 14", {s4_cout, s4_sum});
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({s4_busy, s4_done, s4_cout, s4_sum} !== 7'd0) begin
      failures++;
      $display("FAIL async_reset: busy=%b done=%b cout=%b sum=%0d, required all 0",
               s4_busy, s4_done, s4_cout, s4_sum);
    end
    tick();
    rst = 1'b0;
    tick();
    start_op(4, 1, 2, 1'b0);
    wait_done(4, 1, "after_reset");
  endtask

  task automatic test_width1();
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      start_op(1, 32'(v[2]), 32'(v[1]), v[0]);
      wait_done(1, 1, "w1_combo");
    end
  endtask

  task automatic test_random8();
    for (int op = 0; op < 1000; op++) begin
      start_op(8, 32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)));
      for (int k = 1; k <= 16; k++) begin
        s8_a     = 8'($urandom_range(0, 255));
        s8_b     = 8'($urandom_range(0, 255));
        s8_cin   = 1'($urandom_range(0, 1));
        s8_start = 1'($urandom_range(0, 1));
        tick();
      end
      s8_start = 1'b0;
      wait_done(8, 17, "rand8");
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    s1_start = 1'b0; s1_a = 1'b0; s1_b = 1'b0; s1_cin = 1'b0;
    s4_start = 1'b0; s4_a = '0;   s4_b = '0;   s4_cin = 1'b0;
    s8_start = 1'b0; s8_a = '0;   s8_b = '0;   s8_cin = 1'b0;

    test_reset();
    test_latency();
    test_basic();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    test_width1();
    test_random8();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Sequences one shared half_adder cell to perform a WIDTH-bit addition with carry-in, one bit position at a time.
- Each bit takes two half-adder passes:
  - pass 1: a_i + b_i.
  - pass 2: that partial sum + running carry.
- Used where area matters more than latency. Start/busy/done handshake toward the requester.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in; captured on accepted start.
- busy  output  1  high while the operation is in progress (ADD_AB/ADD_C states).
- done  output  1  one-cycle pulse; sum/cout are valid from this cycle.
- sum  output  WIDTH  registered result; held until the next completion.
- cout  output  1  registered carry-out; held until the next completion.

Behaviour:
- Reset (async assert, any state): state=IDLE, busy=0, done=0, sum=0, cout=0, bit index=0, carry register=0, operand shift registers=0.
- States: IDLE, ADD_AB, ADD_C, FINISH. Encoding is binary, 2 bits.
- IDLE:
  - start=1 at edge t: capture a, b, cin into internal registers (carry register <- cin, index <- 0), go to ADD_AB.
  - start=0: stay in IDLE.
- ADD_AB:
  - Drive the half_adder with a_reg[idx], b_reg[idx]; latch its sum into p_reg and its carry into c1_reg.
  - Go to ADD_C.
- ADD_C:
  - Drive the half_adder with p_reg and the carry register.
  - Write its sum into result bit idx; carry register <- c1_reg | half_adder carry.
  - If idx==WIDTH-1, go to FINISH; else idx+1 and go to ADD_AB.
- FINISH:
  - done=1 for exactly this cycle; copy the result and carry register into sum/cout at the entry edge so they are valid while done=1.
  - Go to IDLE next edge.
- Timing and latency:
  - busy=1 in ADD_AB and ADD_C only.
  - Accepted start at edge t gives done=1 in the cycle after edge t+2*WIDTH.
  - Earliest next accepted start is edge t+2*WIDTH+2.
- Handshake rules:
  - start while busy or in FINISH: ignored, no queuing; the requester must re-assert in IDLE.
  - a/b/cin changes after the accepting edge have no effect on the operation in flight.
- Single half_adder instance; its inputs are muxed by state. It is purely combinational, so no extra pipeline latency.
- Arithmetic: {cout,sum} == a + b + cin, computed modulo 2^(WIDTH+1); no overflow flag.
- sum/cout hold their previous result throughout a new operation until that operation's FINISH.
- Reset mid-operation aborts the operation. sum/cout return to 0, not to the prior result.
- WIDTH=1: exactly one ADD_AB/ADD_C pair; done in the cycle after edge t+2.

Decomposition:
- Shared package/header holds:
  - state encodings: IDLE=2'd0, ADD_AB=2'd1, ADD_C=2'd2, FINISH=2'd3.
  - index width constant IDXW = clog2(WIDTH), minimum 1.
- One sub-module: the existing half_adder cell, instantiated once. All sequencing, muxing and registers stay in serial_add_ctrl.

Test Plan:
- WIDTH=4, a=0, b=0, cin=0, start pulsed one cycle:
  - busy high 8 cycles; done pulses in cycle 9; sum=0, cout=0.
- WIDTH=4, a=15, b=1, cin=0: sum=0, cout=1. Then a=7, b=8, cin=1: sum=0, cout=1. Then a=5, b=9, cin=0: sum=14, cout=0.
- Ignored starts:
  - Second start with a=3, b=3 asserted at cycle 3 of the a=5, b=9 operation: ignored; result still 14, only one done pulse.
  - start held high continuously: back-to-back operations with exactly one idle cycle between the done pulse and the next busy.
- Reset mid-operation:
  - rst asserted during ADD_C of bit 2 (prior result 14): busy, done, sum, cout go to 0 immediately (asynchronous).
  - After release, a new op a=1, b=2 gives sum=3.
- WIDTH=1, all 8 combinations of a/b/cin: {cout,sum} equals the arithmetic sum; done in the cycle after edge t+2.
- WIDTH=8 random regression, 1000 ops, operands changed while busy: every result matches a+b+cin for the operands captured at the accepting edge.
